// File: rtl/fc_mac_requant.sv
// fc_mac_requant: streaming int8 dot-product neuron with bias, optional ReLU and fixed-point requantization.
// Define FC_REQUANT_SATURATE_EN to clamp the output to int8; otherwise the output is truncated to 8 bits.
module fc_mac_requant #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_in_ready,
    input  logic signed [7:0]       i_act,
    input  logic signed [7:0]       i_wgt,
    input  logic                    i_last,
    input  logic signed [7:0]       i_input_zp,
    input  logic signed [7:0]       i_filter_zp,
    input  logic signed [7:0]       i_output_zp,
    input  logic signed [ACC_W-1:0] i_bias,
    input  logic signed [31:0]      i_quant_mult,
    input  logic signed [31:0]      i_quant_shift,
    input  logic                    i_relu_en,
    output logic                    o_valid,
    input  logic                    i_out_ready,
    output logic signed [7:0]       o_data,
    output logic [CNT_W-1:0]        o_beat_cnt
);
    typedef enum logic [2:0] {S_ACC, S_BIAS, S_MUL, S_SHIFT, S_OUT} state_t;
    state_t                  r_state, w_next;
    logic signed [ACC_W-1:0] r_acc, r_res, w_sum;
    logic signed [63:0]      r_p64, w_p64;
    logic signed [31:0]      w_t, w_prod;
    logic signed [15:0]      w_a16, w_w16, w_y16;
    logic signed [7:0]       r_data, w_q;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_valid, w_fire;
    assign o_in_ready = (r_state == S_ACC);
    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_beat_cnt = r_cnt;
    assign w_fire  = i_valid && o_in_ready;
    assign w_a16   = 16'(i_act) - 16'(i_input_zp);
    assign w_w16   = 16'(i_wgt) - 16'(i_filter_zp);
    assign w_prod  = 32'(w_a16) * 32'(w_w16);
    assign w_sum   = r_acc + i_bias;
    // t = 31 - shift; the rounding constant is half an output LSB at that shift
    assign w_t     = 32'sd31 - i_quant_shift;
    assign w_p64   = 64'(r_res) * 64'(i_quant_mult) + (64'sd1 <<< (w_t - 32'sd1));
    assign w_y16   = 16'(r_p64 >>> w_t) + 16'(i_output_zp);
`ifdef FC_REQUANT_SATURATE_EN
    assign w_q = (w_y16 > 16'sd127) ? 8'sd127 : (w_y16 < -16'sd128) ? -8'sd128 : w_y16[7:0];
`else
    assign w_q = 8'(w_y16);
`endif
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_ACC;
        else       r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_ACC:   w_next = (w_fire && i_last) ? S_BIAS : S_ACC;
            S_BIAS:  w_next = S_MUL;
            S_MUL:   w_next = S_SHIFT;
            S_SHIFT: w_next = S_OUT;
            S_OUT:   w_next = i_out_ready ? S_ACC : S_OUT;
            default: w_next = S_ACC;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc   <= '0;
            r_res   <= '0;
            r_p64   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_ACC: if (w_fire) begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_BIAS:  r_res <= (i_relu_en && w_sum < 0) ? '0 : w_sum;
                S_MUL:   r_p64 <= w_p64;
                S_SHIFT: begin
                    r_data  <= w_q;
                    r_valid <= 1'b1;
                end
                S_OUT: if (i_out_ready) begin
                    r_valid <= 1'b0;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fc_mac_requant.sv
// tb_fc_mac_requant: directed vector table plus multi-beat, backpressure and reset sequences.
module tb_fc_mac_requant;
`ifdef FC_REQUANT_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_valid = 1'b0;
    logic               i_last = 1'b0;
    logic               i_relu_en = 1'b0;
    logic               i_out_ready = 1'b0;
    logic signed [7:0]  i_act = '0, i_wgt = '0, i_input_zp = '0, i_filter_zp = '0, i_output_zp = '0;
    logic signed [31:0] i_bias = '0, i_quant_mult = '0, i_quant_shift = '0;
    logic               o_in_ready, o_valid;
    logic [7:0]         o_data;
    logic [9:0]         o_beat_cnt;
    int                 n_chk = 0, n_err = 0;

    typedef struct {
        logic signed [7:0]  act, wgt, izp, fzp, ozp;
        logic signed [31:0] bias, mult, shift;
        logic               relu;
        logic [7:0]         exp;
    } vec_t;
    vec_t tbl[6];

    fc_mac_requant dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_in_ready(o_in_ready),
        .i_act(i_act), .i_wgt(i_wgt), .i_last(i_last),
        .i_input_zp(i_input_zp), .i_filter_zp(i_filter_zp), .i_output_zp(i_output_zp),
        .i_bias(i_bias), .i_quant_mult(i_quant_mult), .i_quant_shift(i_quant_shift),
        .i_relu_en(i_relu_en), .o_valid(o_valid), .i_out_ready(i_out_ready),
        .o_data(o_data), .o_beat_cnt(o_beat_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_cfg(input vec_t v);
        i_input_zp = v.izp; i_filter_zp = v.fzp; i_output_zp = v.ozp;
        i_bias = v.bias; i_quant_mult = v.mult; i_quant_shift = v.shift; i_relu_en = v.relu;
    endtask

    task automatic beat(input logic signed [7:0] a, input logic signed [7:0] w, input logic last);
        i_act = a; i_wgt = w; i_last = last; i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_last = 1'b0;
    endtask

    // called #1 after the edge that accepted the last beat
    task automatic finish_vec(input string name, input logic [7:0] exp, input int cnt, input int hold);
        chk({name, " in_ready after last"}, {31'b0, o_in_ready}, 0);
        for (int k = 1; k <= 3; k++) begin
            @(posedge i_clk); #1;
            chk({name, " valid latency"}, {31'b0, o_valid}, (k == 3) ? 1 : 0);
        end
        chk({name, " data"}, {24'b0, o_data}, {24'b0, exp});
        chk({name, " beat_cnt at out"}, {22'b0, o_beat_cnt}, cnt);
        for (int h = 0; h < hold; h++) begin
            i_valid = 1'b1;
            @(posedge i_clk); #1;
            chk({name, " hold valid"}, {31'b0, o_valid}, 1);
            chk({name, " hold data"}, {24'b0, o_data}, {24'b0, exp});
            chk({name, " hold in_ready"}, {31'b0, o_in_ready}, 0);
            chk({name, " hold beat_cnt"}, {22'b0, o_beat_cnt}, cnt);
        end
        i_valid = 1'b0;
        i_out_ready = 1'b1;
        @(posedge i_clk); #1;
        i_out_ready = 1'b0;
        chk({name, " valid after hs"}, {31'b0, o_valid}, 0);
        chk({name, " in_ready after hs"}, {31'b0, o_in_ready}, 1);
        chk({name, " beat_cnt after hs"}, {22'b0, o_beat_cnt}, 0);
    endtask

    initial begin
        vec_t v;
        tbl[0] = '{act: 8'sd10, wgt: 8'sd3, izp: -8'sd128, fzp: 8'sd0, ozp: 8'sd0, bias: 32'sd0,
                   mult: 32'sh40000000, shift: 32'sd0, relu: 1'b1, exp: SAT ? 8'h7F : 8'hCF};
        tbl[1] = '{act: -8'sd128, wgt: 8'sd1, izp: 8'sd0, fzp: 8'sd0, ozp: -8'sd5, bias: 32'sd0,
                   mult: 32'sh40000000, shift: 32'sd0, relu: 1'b1, exp: 8'hFB};
        tbl[2] = '{act: -8'sd3, wgt: 8'sd1, izp: 8'sd0, fzp: 8'sd0, ozp: 8'sd0, bias: 32'sd0,
                   mult: 32'sh40000000, shift: 32'sd0, relu: 1'b0, exp: 8'hFF};
        tbl[3] = '{act: 8'sd100, wgt: 8'sd100, izp: 8'sd0, fzp: 8'sd0, ozp: -8'sd100, bias: 32'sd0,
                   mult: 32'sh40000000, shift: -32'sd4, relu: 1'b0, exp: 8'hD5};
        tbl[4] = '{act: 8'sd7, wgt: -8'sd2, izp: 8'sd2, fzp: 8'sd3, ozp: 8'sd3, bias: 32'sd10,
                   mult: 32'sh40000000, shift: 32'sd1, relu: 1'b0, exp: 8'hF4};
        tbl[5] = '{act: -8'sd128, wgt: 8'sd127, izp: 8'sd0, fzp: 8'sd0, ozp: 8'sd0, bias: 32'sd0,
                   mult: 32'sh40000000, shift: 32'sd0, relu: 1'b0, exp: SAT ? 8'h80 : 8'h40};
        if (SAT) tbl[3].exp = 8'h7F;
        #2;
        chk("reset valid", {31'b0, o_valid}, 0);
        chk("reset data", {24'b0, o_data}, 0);
        chk("reset beat_cnt", {22'b0, o_beat_cnt}, 0);
        @(posedge i_clk); @(posedge i_clk); #1;
        i_rst = 1'b0;
        chk("reset in_ready", {31'b0, o_in_ready}, 1);

        for (int i = 0; i < 6; i++) begin
            set_cfg(tbl[i]);
            beat(tbl[i].act, tbl[i].wgt, 1'b1);
            finish_vec($sformatf("vec%0d", i), tbl[i].exp, 1, 0);
        end

        // three beats with an idle gap: 2 + 12 + 30 = 44 -> 22
        v = tbl[2]; v.relu = 1'b0; set_cfg(v);
        beat(8'sd1, 8'sd2, 1'b0);
        beat(8'sd3, 8'sd4, 1'b0);
        repeat (3) @(posedge i_clk);
        #1 chk("gap beat_cnt", {22'b0, o_beat_cnt}, 2);
        beat(8'sd5, 8'sd6, 1'b1);
        finish_vec("multi", 8'h16, 3, 0);

        // 784 beats with act == input zero-point: only the bias survives
        v.izp = 8'sd5; v.bias = 32'sd1000; set_cfg(v);
        for (int b = 0; b < 784; b++) beat(8'sd5, 8'(signed'($urandom_range(255))), (b == 783) ? 1'b1 : 1'b0);
        finish_vec("len784", SAT ? 8'h7F : 8'hF4, 784, 0);

        // output backpressure for 5 cycles
        set_cfg(tbl[1]);
        beat(tbl[1].act, tbl[1].wgt, 1'b1);
        finish_vec("bp", 8'hFB, 1, 5);

        // reset in the middle of a vector discards the partial sum
        v = tbl[2]; set_cfg(v);
        for (int b = 0; b < 100; b++) beat(8'sd1, 8'sd1, 1'b0);
        chk("pre-reset beat_cnt", {22'b0, o_beat_cnt}, 100);
        i_rst = 1'b1;
        #2;
        chk("async reset beat_cnt", {22'b0, o_beat_cnt}, 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        beat(8'sd10, 8'sd3, 1'b1);
        finish_vec("after reset", 8'h0F, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fc_mac_requant.md
Name: fc_mac_requant

Overview:
- Streaming neuron engine for the quantized MNIST fully-connected layers.
- Consumes one int8 activation/weight pair per beat and removes the input and filter zero-points.
- Forms the exact 16x16 signed product and accumulates it in 32 bits.
- On the last beat it adds bias, applies optional ReLU, requantizes (multiply, round, shift, add output zero-point) and emits one int8 output neuron.
- Sits directly downstream of the layer input/weight buffers; its int8 outputs feed the next layer's activation buffer.

Parameters:
- ACC_W, 32, accumulator and bias width.
- CNT_W, 10, beat-counter width. Covers the 784-input layer.

Ports:
- i_clk  input  1  clock; all state changes on the rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  input beat valid.
- o_in_ready  output  1  block can accept a beat.
- i_act  input  8  signed activation.
- i_wgt  input  8  signed weight.
- i_last  input  1  final beat of the current dot product.
- i_input_zp  input  8  signed input zero-point.
- i_filter_zp  input  8  signed filter zero-point.
- i_output_zp  input  8  signed output zero-point.
- i_bias  input  ACC_W  signed bias.
- i_quant_mult  input  32  signed requant multiplier.
- i_quant_shift  input  32  signed requant shift.
- i_relu_en  input  1  1 = clamp negative values to 0 before requant.
- o_valid  output  1  output neuron valid.
- i_out_ready  input  1  downstream accepts the output.
- o_data  output  8  signed int8 neuron output.
- o_beat_cnt  output  CNT_W  beats accepted in the current vector.

Behaviour:
- Clock/reset:
  - One clock, i_clk. Reset i_rst is asynchronous and active-high.
  - On reset: state=S_ACC, acc=0, o_valid=0, o_data=0, o_beat_cnt=0, o_in_ready=1 (once reset is released).
  - Reset asserted mid-vector or mid-requant discards all partial work.
- Configuration inputs (zero-points, bias, quant, relu_en):
  - Must be held stable from the first beat until the output handshake.
  - They are not latched.
- FSM states: S_ACC, S_BIAS, S_MUL, S_SHIFT, S_OUT.
  - S_ACC:
    - o_in_ready=1. A beat fires when i_valid && o_in_ready.
    - Per beat: a16 = sext(i_act) - sext(i_input_zp); w16 = sext(i_wgt) - sext(i_filter_zp).
    - acc <= acc + a16*w16, with a 32-bit signed product and two's-complement wrap on the accumulator.
    - o_beat_cnt increments, wrapping at 2^CNT_W.
    - A beat with i_last moves to S_BIAS.
    - A single-beat vector (i_last on the first beat) is legal.
  - S_BIAS:
    - s = acc + i_bias.
    - r = (i_relu_en && s<0) ? 0 : s.
    - Go to S_MUL. o_in_ready=0 from here until the output handshake.
  - S_MUL:
    - t = 31 - i_quant_shift. Legal range of t is 1..62; behaviour outside this range is undefined.
    - p64 <= sext64(r)*sext64(i_quant_mult) + (1<<(t-1)).
  - S_SHIFT:
    - y16 = (p64 >>> t) + sext(i_output_zp), computed in 16-bit signed.
    - o_data <= saturate or truncate per the Optional Feature.
    - o_valid <= 1; go to S_OUT.
  - S_OUT:
    - o_valid=1; o_data is held stable.
    - On i_out_ready: o_valid <= 0, acc <= 0, o_beat_cnt <= 0, return to S_ACC.
    - The next vector's first beat is accepted on the cycle after the handshake. There is no overlap.
- Latency: last beat accepted at edge N gives o_valid=1 after edge N+3.
- Throughput: 1 beat/cycle while accumulating; 4-cycle minimum per-neuron overhead (3 requant stages plus the handshake cycle).
- If i_out_ready is held high, the output handshake completes at edge N+4.
- i_valid=0 during S_ACC: hold all state.

Optional Feature:
- Macro: FC_REQUANT_SATURATE_EN.
- Defined: o_data = clamp(y16, -128, 127).
- Undefined: o_data = y16[7:0] (plain truncation), bit-matching the existing software layer model.

Test Plan:
- Truncation case, FC_REQUANT_SATURATE_EN undefined:
  - Stimulus: single beat act=10, in_zp=-128, wgt=3, fzp=0, bias=0, mult=0x40000000, shift=0, relu=1, out_zp=0.
  - Response: acc=414, y16=207, o_data=0xCF. o_valid rises exactly 3 cycles after the beat.
- Saturation case: same stimulus with FC_REQUANT_SATURATE_EN defined -> o_data=0x7F.
- ReLU: act=-128, zp=0, wgt=1, bias=0, relu=1, out_zp=-5 -> o_data=0xFB (-5).
- Negative rounding without ReLU: acc=-3 (act=-3, wgt=1), relu=0, mult=0x40000000, shift=0, out_zp=0 -> o_data=0xFF (-1).
- 784-beat vector:
  - Stimulus: every act=in_zp, random weights, bias=1000, mult=0x40000000, shift=0.
  - Response: acc=1000 entering requant, o_data=0xF4 (500 truncated). o_beat_cnt reads 784 at S_OUT.
- Backpressure and reset:
  - Holding i_out_ready=0 for 5 cycles keeps o_valid=1, o_data stable and o_in_ready=0.
  - Asserting i_rst mid-vector (beat 100) then restarting a 1-beat vector gives a result equal to that beat alone.
